// File: rtl/dac_pkg.sv
// Shared types and defaults for the DAC sample sequencer.
package dac_pkg;

  localparam int unsigned DacDataW = 16;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StAck,
    StXfer
  } seq_state_e;

endpackage

// File: rtl/dac_sample_fifo.sv
// Synchronous FIFO with extra-bit wrap pointers and a registered read port.
module dac_sample_fifo
  import dac_pkg::*;
#(
  parameter int unsigned DATA_W = DacDataW,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [DATA_W-1:0]         wdata,
  input  logic                      pop,
  output logic [DATA_W-1:0]         rdata,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr_q;
  logic [AW:0]       rd_ptr_q;
  logic [DATA_W-1:0] rdata_q;
  logic              push_ok;
  logic              pop_ok;

  // Full refuses a push even when a pop lands in the same cycle.
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign level   = wr_ptr_q - rd_ptr_q;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = rdata_q;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rdata_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        rdata_q  <= mem[rd_ptr_q[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/dac_sample_sequencer.sv
// Paces buffered DAC codes into the SPI master: one transfer per sample period,
// with sticky underrun/overrun reporting.
module dac_sample_sequencer
  import dac_pkg::*;
#(
  parameter int unsigned DATA_W = DacDataW,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DIV_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [DIV_W-1:0]       rate_div,
  input  logic                   s_valid,
  input  logic [DATA_W-1:0]      s_data,
  output logic                   s_ready,
  input  logic                   spi_busy,
  output logic [DATA_W-1:0]      dac_code,
  output logic                   dac_start,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   underrun,
  output logic                   overrun,
  input  logic                   clr_flags
);

  logic [DIV_W-1:0] cnt_q;
  seq_state_e       state_q;
  logic             tick;
  logic             pop;
  logic             full;
  logic             empty;

  assign tick    = enable && (cnt_q == '0);
  assign pop     = tick && (state_q == StIdle) && !spi_busy;
  assign s_ready = !full;

  // The FIFO read register doubles as the dac_code output register.
  dac_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s_valid),
    .wdata (s_data),
    .pop   (pop),
    .rdata (dac_code),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst || !enable || tick) begin
      cnt_q <= rate_div;
    end else begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      dac_start <= 1'b0;
      underrun  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      dac_start <= 1'b0;
      if (clr_flags) begin
        underrun <= 1'b0;
        overrun  <= 1'b0;
      end
      // Flag sets come after the clear so a same-cycle set wins.
      case (state_q)
        StIdle: begin
          if (tick) begin
            if (spi_busy) begin
              overrun <= 1'b1;
            end else begin
              if (empty) begin
                underrun <= 1'b1;
              end
              state_q   <= StStart;
              dac_start <= 1'b1;
            end
          end
        end
        StStart: state_q <= StAck;
        StAck: begin
          if (spi_busy) begin
            state_q <= StXfer;
          end
        end
        StXfer: begin
          if (!spi_busy) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
      if (tick && (state_q != StIdle)) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dac_sample_sequencer.sv
// Directed bench with a code scoreboard and a 40-cycle SPI busy model.
module tb_dac_sample_sequencer;
  import dac_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] rate_div;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic        spi_busy;
  logic [15:0] dac_code;
  logic        dac_start;
  logic [4:0]  fifo_level;
  logic        underrun;
  logic        overrun;
  logic        clr_flags;

  int          checks = 0;
  int          failures = 0;
  int          n_starts = 0;
  int          cyc = 0;
  int          busy_cnt;
  int          start_cyc[$];
  logic [15:0] exp_q[$];
  logic        prev_start = 1'b0;

  always #5 clk = ~clk;

  dac_sample_sequencer #(
    .DATA_W (16),
    .DEPTH  (16),
    .DIV_W  (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .rate_div   (rate_div),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .spi_busy   (spi_busy),
    .dac_code   (dac_code),
    .dac_start  (dac_start),
    .fifo_level (fifo_level),
    .underrun   (underrun),
    .overrun    (overrun),
    .clr_flags  (clr_flags)
  );

  // SPI master model: busy rises the cycle after dac_start and lasts 40 cycles.
  always @(posedge clk) begin
    if (rst) begin
      spi_busy <= 1'b0;
      busy_cnt <= 0;
    end else if (dac_start) begin
      spi_busy <= 1'b1;
      busy_cnt <= 40;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) spi_busy <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every launch pops the next expected code.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst && dac_start) begin
        chk("start_one_cycle", 32'(prev_start), 32'd0);
        n_starts++;
        start_cyc.push_back(cyc);
        checks++;
        assert (exp_q.size() != 0) else begin
          failures++;
          $error("FAIL sb_empty observed=start expected=no_start code=0x%0h", dac_code);
        end
        if (exp_q.size() != 0) chk("dac_code", 32'(dac_code), 32'(exp_q.pop_front()));
      end
      prev_start = dac_start && !rst;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] d, input bit expect_out);
    s_valid = 1'b1;
    s_data  = d;
    step();
    s_valid = 1'b0;
    if (expect_out) exp_q.push_back(d);
  endtask

  task automatic wait_start(input int target, input int budget);
    int n = 0;
    while (n_starts < target && n < budget) begin
      step();
      n++;
    end
    checks++;
    assert (n_starts >= target) else begin
      failures++;
      $error("FAIL wait_start observed=%0d expected=%0d", n_starts, target);
    end
  endtask

  task automatic wait_state(input seq_state_e st, input int budget);
    int n = 0;
    while (dut.state_q != st && n < budget) begin
      step();
      n++;
    end
    chk("wait_state", 32'(dut.state_q), 32'(st));
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; enable = 1'b0; rate_div = 16'd99;
    s_valid = 1'b0; s_data = '0; clr_flags = 1'b0;
    repeat (3) step();

    chk("rst_dac_code", 32'(dac_code), 32'd0);
    chk("rst_dac_start", 32'(dac_start), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_cnt", 32'(dut.cnt_q), 32'd99);
    chk("rst_state", 32'(dut.state_q), 32'(StIdle));
    rst = 1'b0;
    step();

    // Normal pacing at 100 cycles per sample.
    push_word(16'h1000, 1'b1);
    push_word(16'h2000, 1'b1);
    push_word(16'h3000, 1'b1);
    step();
    chk("level_3", 32'(fifo_level), 32'd3);
    enable = 1'b1;
    wait_start(1, 150);
    chk("level_2", 32'(fifo_level), 32'd2);
    wait_start(2, 150);
    chk("level_1", 32'(fifo_level), 32'd1);
    wait_start(3, 150);
    chk("level_0", 32'(fifo_level), 32'd0);
    chk("pace_underrun", 32'(underrun), 32'd0);
    chk("pace_overrun", 32'(overrun), 32'd0);
    chk("period_1", 32'(start_cyc[1] - start_cyc[0]), 32'd100);
    chk("period_2", 32'(start_cyc[2] - start_cyc[1]), 32'd100);

    // Underrun: empty FIFO repeats the last code.
    exp_q.push_back(16'h3000);
    wait_start(4, 150);
    chk("underrun_set", 32'(underrun), 32'd1);
    chk("underrun_no_overrun", 32'(overrun), 32'd0);
    enable = 1'b0;
    pulse_clr();
    chk("underrun_clr", 32'(underrun), 32'd0);
    repeat (60) step();

    // Overrun: 20-cycle period against 40-cycle busy.
    rate_div = 16'd19;
    push_word(16'hA001, 1'b1);
    push_word(16'hA002, 1'b1);
    push_word(16'hA003, 1'b1);
    enable = 1'b1;
    wait_start(5, 60);
    chk("ovr_level_2", 32'(fifo_level), 32'd2);
    wait_start(6, 100);
    chk("ovr_level_1", 32'(fifo_level), 32'd1);
    chk("overrun_set", 32'(overrun), 32'd1);
    chk("ovr_period", 32'(start_cyc[5] - start_cyc[4]), 32'd60);
    wait_start(7, 100);
    chk("ovr_level_0", 32'(fifo_level), 32'd0);
    enable = 1'b0;
    repeat (60) step();
    chk("ovr_no_underrun", 32'(underrun), 32'd0);
    pulse_clr();
    chk("overrun_clr", 32'(overrun), 32'd0);

    // Full FIFO: 17 pushes with the timer stopped; the last is refused.
    rate_div = 16'd49;
    for (int i = 0; i < 17; i++) begin
      if (i == 16) chk("s_ready_full", 32'(s_ready), 32'd0);
      s_valid = 1'b1;
      s_data  = 16'hB000 + 16'(i);
      if (i < 16) exp_q.push_back(s_data);
      step();
    end
    s_valid = 1'b0;
    step();
    chk("full_level", 32'(fifo_level), 32'd16);
    chk("full_s_ready", 32'(s_ready), 32'd0);
    exp_q.push_back(16'hB00F);
    enable = 1'b1;
    wait_start(23, 16 * 60);
    chk("drain_no_underrun", 32'(underrun), 32'd0);
    wait_start(24, 100);
    chk("drain_underrun", 32'(underrun), 32'd1);
    chk("drain_level", 32'(fifo_level), 32'd0);
    enable = 1'b0;
    repeat (60) step();
    pulse_clr();

    // Enable dropped during ACK: transfer completes, timer holds.
    rate_div = 16'd29;
    push_word(16'hC0DE, 1'b1);
    enable = 1'b1;
    wait_start(25, 60);
    step();
    chk("in_ack", 32'(dut.state_q), 32'(StAck));
    enable = 1'b0;
    wait_state(StXfer, 10);
    wait_state(StIdle, 80);
    repeat (100) step();
    chk("no_more_starts", 32'(n_starts), 32'd25);
    chk("cnt_held", 32'(dut.cnt_q), 32'd29);
    chk("drop_level", 32'(fifo_level), 32'd0);

    // Reset in XFER with a flag set and a word still buffered.
    rate_div = 16'd19;
    push_word(16'h1111, 1'b1);
    push_word(16'h2222, 1'b0);
    enable = 1'b1;
    wait_start(26, 40);
    n = 0;
    while (!(dut.state_q == StXfer && overrun) && n < 60) begin
      step();
      n++;
    end
    chk("pre_rst_overrun", 32'(overrun), 32'd1);
    chk("pre_rst_level", 32'(fifo_level), 32'd1);
    rst = 1'b1;
    step();
    chk("mid_rst_state", 32'(dut.state_q), 32'(StIdle));
    chk("mid_rst_code", 32'(dac_code), 32'd0);
    chk("mid_rst_start", 32'(dac_start), 32'd0);
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    chk("mid_rst_underrun", 32'(underrun), 32'd0);
    chk("mid_rst_overrun", 32'(overrun), 32'd0);
    chk("mid_rst_cnt", 32'(dut.cnt_q), 32'd19);
    exp_q.delete();
    enable = 1'b0;
    rst = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
